// File: rtl/shftreg_pkg.sv
// Shared encodings for the shift-register command sequencer.
// Op codes match the cmd_op field; states cover the sequencer FSM.
package shftreg_pkg;

    localparam int W = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        IDLE     = 3'd1,
        LOAD     = 3'd2,
        SHIFT    = 3'd3,
        CLR      = 3'd4,
        RESP     = 3'd5
    } state_t;

endpackage

// File: rtl/shftreg_seq.sv
// Command sequencer driving a falling-edge 4-bit shift register.
// Idle cycles reload the register from its own output to hold it.
module shftreg_seq #(
    parameter int W     = 4,
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [W-1:0]     cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    input  logic [W-1:0]     D,
    output logic             LD,
    output logic             RL,
    output logic             InS,
    output logic [W-1:0]     InP,
    output logic             Clear
);
    import shftreg_pkg::*;

    state_t           r_state;
    logic [W-1:0]     r_sdata;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= RST_HOLD;
            r_sdata   <= '0;
            r_cnt     <= '0;
            Clear     <= 1'b0;
            LD        <= 1'b1;
            RL        <= 1'b0;
            InS       <= 1'b0;
            InP       <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            // Hold outputs: reload current contents unless a state overrides.
            LD    <= 1'b1;
            Clear <= 1'b1;
            RL    <= 1'b0;
            InS   <= 1'b0;
            InP   <= D;
            unique case (r_state)
                RST_HOLD: begin
                    cmd_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        r_sdata   <= cmd_data >> 1;
                        r_cnt     <= cmd_count;
                        unique case (cmd_op)
                            OP_LOAD: begin
                                InP     <= cmd_data;
                                r_state <= LOAD;
                            end
                            OP_SHR, OP_SHL: begin
                                LD      <= 1'b0;
                                RL      <= (cmd_op == OP_SHL);
                                InS     <= cmd_data[0];
                                r_state <= SHIFT;
                            end
                            OP_CLR: begin
                                Clear   <= 1'b0;
                                r_state <= CLR;
                            end
                        endcase
                    end
                end
                LOAD, CLR: begin
                    rsp_data  <= D;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                SHIFT: begin
                    if (r_cnt == '0) begin
                        rsp_data  <= D;
                        rsp_valid <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        LD      <= 1'b0;
                        RL      <= RL;
                        InS     <= r_sdata[0];
                        r_sdata <= r_sdata >> 1;
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shftreg_seq.sv
// Bench for shftreg_seq with a behavioural falling-edge shift register
// and a transaction-level model of the expected register contents.
module tb_shftreg_seq;

    logic       CLK;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [1:0] cmd_count;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [3:0] D;
    logic       LD;
    logic       RL;
    logic       InS;
    logic [3:0] InP;
    logic       Clear;

    int pass_cnt = 0;
    int total = 0;
    logic [3:0] exp_q;
    logic [3:0] trace[$];
    logic acc_clear;

    shftreg_seq #(.W(4), .CNT_W(2)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .D(D), .LD(LD), .RL(RL), .InS(InS), .InP(InP), .Clear(Clear)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shift register: async active-low clear, acts on falling edge.
    always @(negedge CLK or negedge Clear) begin
        if (!Clear)   D <= 4'b0000;
        else if (LD)  D <= InP;
        else if (!RL) D <= {InS, D[3:1]};
        else          D <= {D[2:0], InS};
    end

    function automatic logic [3:0] step(input logic [3:0] q, input logic left, input logic b);
        return left ? {q[2:0], b} : {b, q[3:1]};
    endfunction

    function automatic logic [3:0] model(input logic [3:0] q, input logic [1:0] op,
                                         input logic [3:0] d, input int cnt);
        logic [3:0] r;
        r = q;
        case (op)
            2'b00: r = d;
            2'b01: for (int i = 0; i <= cnt; i++) r = step(r, 1'b0, d[i]);
            2'b10: for (int i = 0; i <= cnt; i++) r = step(r, 1'b1, d[i]);
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] data, input int cnt,
                            output int lat, output logic [3:0] rdata);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge CLK); #1; w++;
        end
        if (!cmd_ready) begin
            total++;
            $display("FAIL cmd_ready_timeout got=%b want=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = cnt[1:0];
        @(posedge CLK); #1;
        acc_clear = Clear;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 4'($urandom);
        cmd_count = 2'($urandom);
        trace.delete();
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge CLK); #1; lat++;
            trace.push_back(D);
        end
        rdata = rsp_data;
        if (!rsp_valid) begin
            total++;
            $display("FAIL rsp_valid_timeout got=%b want=1", rsp_valid);
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (Clear !== 1'b0) $display("FAIL rst_clear got=%b want=0", Clear); else pass_cnt++;
        total++; if (LD !== 1'b1) $display("FAIL rst_ld got=%b want=1", LD); else pass_cnt++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got=%b want=0", cmd_ready); else pass_cnt++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); else pass_cnt++;
        total++; if (rsp_data !== 4'b0000) $display("FAIL rst_rsp_data got=%b want=0000", rsp_data); else pass_cnt++;
        total++; if (InP !== 4'b0000) $display("FAIL rst_inp got=%b want=0000", InP); else pass_cnt++;
        total++; if (D !== 4'b0000) $display("FAIL rst_d got=%b want=0000", D); else pass_cnt++;
        RST = 1'b0;
        @(posedge CLK); #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL rel_cmd_ready got=%b want=1", cmd_ready); else pass_cnt++;
        total++; if ({Clear, LD} !== 2'b11) $display("FAIL rel_clear_ld got=%b want=11", {Clear, LD}); else pass_cnt++;
        exp_q = 4'b0000;
    endtask

    task automatic test_load_hold();
        int lat;
        int bad;
        logic [3:0] r;
        send_cmd(2'b00, 4'b1010, 2, lat, r);
        exp_q = model(exp_q, 2'b00, 4'b1010, 2);
        total++; if (lat !== 1) $display("FAIL load_lat got=%0d want=1", lat); else pass_cnt++;
        total++; if (r !== exp_q) $display("FAIL load_data got=%b want=%b", r, exp_q); else pass_cnt++;
        ack_rsp();
        bad = 0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (D !== exp_q) bad++;
        end
        total++; if (bad != 0) $display("FAIL idle_hold got=%b bad=%0d want=%b", D, bad, exp_q); else pass_cnt++;
    endtask

    task automatic test_shift_r();
        int lat;
        logic [3:0] r;
        logic [3:0] want[4];
        send_cmd(2'b00, 4'b0000, 0, lat, r);
        ack_rsp();
        exp_q = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            exp_q = step(exp_q, 1'b0, (4'b0110 >> i) & 4'b0001 ? 1'b1 : 1'b0);
            want[i] = exp_q;
        end
        send_cmd(2'b01, 4'b0110, 3, lat, r);
        total++; if (lat !== 4) $display("FAIL shr_lat got=%0d want=4", lat); else pass_cnt++;
        total++; if (r !== 4'b0110) $display("FAIL shr_data got=%b want=0110", r); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= trace.size() || trace[i] !== want[i])
                $display("FAIL shr_step%0d got=%b want=%b", i, (i < trace.size()) ? trace[i] : 4'bx, want[i]);
            else pass_cnt++;
        end
        ack_rsp();
    endtask

    task automatic test_shift_l();
        int lat;
        logic [3:0] r;
        send_cmd(2'b00, 4'b1010, 0, lat, r);
        ack_rsp();
        exp_q = model(4'b1010, 2'b10, 4'b0001, 0);
        send_cmd(2'b10, 4'b0001, 0, lat, r);
        total++; if (lat !== 1) $display("FAIL shl_lat got=%0d want=1", lat); else pass_cnt++;
        total++; if (r !== 4'b0101) $display("FAIL shl_data got=%b want=0101", r); else pass_cnt++;
        ack_rsp();
    endtask

    task automatic test_clear();
        int lat;
        logic [3:0] r;
        send_cmd(2'b00, 4'b0110, 0, lat, r);
        ack_rsp();
        send_cmd(2'b11, 4'b1111, 3, lat, r);
        exp_q = 4'b0000;
        total++; if (acc_clear !== 1'b0) $display("FAIL clr_low got=%b want=0", acc_clear); else pass_cnt++;
        total++; if (lat !== 1) $display("FAIL clr_lat got=%0d want=1", lat); else pass_cnt++;
        total++; if (r !== exp_q) $display("FAIL clr_data got=%b want=%b", r, exp_q); else pass_cnt++;
        total++; if ({Clear, LD} !== 2'b11) $display("FAIL clr_after got=%b want=11", {Clear, LD}); else pass_cnt++;
        ack_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [3:0] r;
        send_cmd(2'b00, 4'b1111, 0, lat, r);
        exp_q = 4'b1111;
        bad = 0;
        repeat (5) begin
            @(posedge CLK); #1;
            if (!rsp_valid || rsp_data !== exp_q || cmd_ready || D !== exp_q) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL bp_hold got=v%b d%b r%b q%b want=v1 d%b r0 q%b",
                     rsp_valid, rsp_data, cmd_ready, D, exp_q, exp_q);
        else pass_cnt++;
        ack_rsp();
        total++; if (cmd_ready !== 1'b1) $display("FAIL bp_ready got=%b want=1", cmd_ready); else pass_cnt++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL bp_rsp_drop got=%b want=0", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [3:0] r;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 4'b1011;
        cmd_count = 2'd3;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        total++; if (Clear !== 1'b0) $display("FAIL mid_clear got=%b want=0", Clear); else pass_cnt++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp got=%b want=0", rsp_valid); else pass_cnt++;
        total++; if (D !== 4'b0000) $display("FAIL mid_d got=%b want=0000", D); else pass_cnt++;
        RST = 1'b0;
        exp_q = 4'b0000;
        send_cmd(2'b00, 4'b0011, 0, lat, r);
        exp_q = 4'b0011;
        total++; if (r !== exp_q) $display("FAIL mid_load got=%b want=%b", r, exp_q); else pass_cnt++;
        ack_rsp();
    endtask

    task automatic test_random();
        int lat;
        int cnt;
        int dly;
        int bad;
        int want_lat;
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] r;
        logic [3:0] q;
        logic [3:0] want[$];
        for (int n = 0; n < 24; n++) begin
            op   = 2'($urandom_range(0, 3));
            data = 4'($urandom);
            cnt  = $urandom_range(0, 3);
            want.delete();
            q = exp_q;
            if (op == 2'b01 || op == 2'b10) begin
                for (int i = 0; i <= cnt; i++) begin
                    q = step(q, op == 2'b10, data[i]);
                    want.push_back(q);
                end
            end
            exp_q = model(exp_q, op, data, cnt);
            want_lat = (op == 2'b01 || op == 2'b10) ? cnt + 1 : 1;
            send_cmd(op, data, cnt, lat, r);
            total++; if (lat !== want_lat) $display("FAIL rnd%0d_lat got=%0d want=%0d", n, lat, want_lat); else pass_cnt++;
            total++; if (r !== exp_q) $display("FAIL rnd%0d_data got=%b want=%b", n, r, exp_q); else pass_cnt++;
            bad = 0;
            for (int i = 0; i < want.size(); i++)
                if (i >= trace.size() || trace[i] !== want[i]) bad++;
            total++; if (bad != 0) $display("FAIL rnd%0d_trace bad=%0d want=0", n, bad); else pass_cnt++;
            dly = $urandom_range(0, 3);
            bad = 0;
            repeat (dly) begin
                @(posedge CLK); #1;
                if (!rsp_valid || rsp_data !== exp_q || D !== exp_q) bad++;
            end
            total++; if (bad != 0) $display("FAIL rnd%0d_hold bad=%0d want=0", n, bad); else pass_cnt++;
            ack_rsp();
            total++; if (cmd_ready !== 1'b1) $display("FAIL rnd%0d_ready got=%b want=1", n, cmd_ready); else pass_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'b0000;
        cmd_count = 2'b00;
        rsp_ready = 1'b0;
        acc_clear = 1'b1;
        exp_q     = 4'b0000;
        test_reset();
        test_load_hold();
        test_shift_r();
        test_shift_l();
        test_clear();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
